// File: rtl/ifm_pkg.sv
// Shared definitions for the IFM fetch controller: FSM states, default
// window width and a width helper for derived counter sizes.
package ifm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } ifm_state_e;

    localparam int unsigned IFM_TAPS_DEFAULT = 4;

    // Bits needed to represent values 0..v-1 (at least 1 bit).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ifm_addr_gen.sv
// Row / fetch-column counters and incremental SRAM address generation.
// Addresses advance by one per fetch; a new row restarts at base + IMG_W,
// so no multiplier is needed.
module ifm_addr_gen
    import ifm_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned TAPS   = IFM_TAPS_DEFAULT,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned FC_W   = 5,
    parameter int unsigned ROW_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              fetch_i,
    input  logic              next_row_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [FC_W-1:0]   fc_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              fill_last_o,
    output logic              row_end_o,
    output logic              row_last_o
);

    logic [FC_W-1:0]   fc_q,   fc_d;
    logic [ROW_W-1:0]  row_q,  row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Next-state for counters: frame clear, row advance, or per-fetch step.
    always_comb begin
        fc_d   = fc_q;
        row_d  = row_q;
        base_d = base_q;
        addr_d = addr_q;
        if (clear_i) begin
            fc_d   = '0;
            row_d  = '0;
            base_d = '0;
            addr_d = '0;
        end else if (next_row_i) begin
            fc_d   = '0;
            row_d  = row_q + ROW_W'(1);
            base_d = base_q + ADDR_W'(IMG_W);
            addr_d = base_q + ADDR_W'(IMG_W);
        end else if (fetch_i) begin
            fc_d   = fc_q + FC_W'(1);
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q   <= '0;
            row_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            fc_q   <= fc_d;
            row_q  <= row_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign fc_o        = fc_q;
    assign row_o       = row_q;
    assign fill_last_o = (fc_q == FC_W'(TAPS - 1));
    assign row_end_o   = (fc_q == FC_W'(IMG_W));
    assign row_last_o  = (row_q == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// Sequences the TAPS-deep IFM shift buffer: fills it per row, presents
// windows to the PE array, refetches one pixel per accepted window and
// stalls on PE backpressure.
module ifm_fetch_ctrl
    import ifm_pkg::*;
#(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned TAPS   = IFM_TAPS_DEFAULT,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              ifm_read_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic [IDX_W-1:0]  win_row_o,
    output logic [IDX_W-1:0]  win_col_o
);

    localparam int unsigned FC_W  = clog2(IMG_W + 1);
    localparam int unsigned ROW_W = clog2(IMG_H);

    ifm_state_e        state_q, state_d;
    logic              ifm_read_q;
    logic              mem_en;
    logic              win_valid;
    logic              busy;
    logic              done;
    logic              clear;
    logic              next_row;
    logic [ADDR_W-1:0] addr;
    logic [FC_W-1:0]   fc;
    logic [ROW_W-1:0]  row;
    logic              fill_last;
    logic              row_end;
    logic              row_last;

    ifm_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W),
        .FC_W   (FC_W),
        .ROW_W  (ROW_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .fetch_i     (mem_en),
        .next_row_i  (next_row),
        .mem_addr_o  (addr),
        .fc_o        (fc),
        .row_o       (row),
        .fill_last_o (fill_last),
        .row_end_o   (row_end),
        .row_last_o  (row_last)
    );

    // State register and the one-cycle SRAM-latency shift strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ifm_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ifm_read_q <= mem_en;
        end
    end

    // Next-state and control outputs; everything is forced low while rst is high.
    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        next_row  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clear   = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                if (fill_last) begin
                    state_d = ST_WAIT;
                end
            end
            // The last issued pixel shifts in this cycle and is visible next.
            ST_WAIT: begin
                busy    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                if (win_ready_i) begin
                    if (!row_end) begin
                        mem_en  = 1'b1;
                        state_d = ST_WAIT;
                    end else if (!row_last) begin
                        next_row = 1'b1;
                        state_d  = ST_FILL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            mem_en    = 1'b0;
            win_valid = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            clear     = 1'b0;
            next_row  = 1'b0;
        end
    end

    assign busy_o      = busy;
    assign done_o      = done;
    assign mem_en_o    = mem_en;
    assign mem_addr_o  = rst ? '0 : addr;
    assign ifm_read_o  = ifm_read_q & ~rst;
    assign win_valid_o = win_valid;
    assign win_row_o   = win_valid ? IDX_W'(row) : '0;
    assign win_col_o   = win_valid ? IDX_W'(fc - FC_W'(TAPS)) : '0;

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Directed bench for ifm_fetch_ctrl with an event scoreboard: expected
// fetches, windows and done are queued when a frame is started and are
// matched as the DUT produces them.
module tb_ifm_fetch_ctrl;

    localparam int TAPS = 4;

    typedef struct {
        int c;
        int a;
        int b;
        int d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       win_ready = 1'b1;

    logic       busy_a, done_a, mem_en_a, ifm_read_a, win_valid_a;
    logic [7:0] mem_addr_a;
    logic [3:0] win_row_a, win_col_a;
    logic       busy_b, done_b, mem_en_b, ifm_read_b, win_valid_b;
    logic [7:0] mem_addr_b;
    logic [3:0] win_row_b, win_col_b;

    logic       sel = 1'b0;
    logic       busy_m, done_m, mem_en_m, ifm_read_m, win_valid_m;
    logic [7:0] mem_addr_m;
    logic [3:0] win_row_m, win_col_m;

    int   checks = 0;
    int   errors = 0;
    int   tick = 0;
    int   base = 0;
    int   mode = 0;
    bit   active = 1'b0;
    int   done_cyc = 0;
    int   ndone = 0;
    bit   seen = 1'b0;
    logic prev_me = 1'b0;
    ev_t  fq[$];
    ev_t  wq[$];

    ifm_fetch_ctrl #(.IMG_W(6), .IMG_H(2), .TAPS(TAPS), .ADDR_W(8), .IDX_W(4)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .mem_en_o(mem_en_a), .mem_addr_o(mem_addr_a), .ifm_read_o(ifm_read_a),
        .win_valid_o(win_valid_a), .win_ready_i(win_ready),
        .win_row_o(win_row_a), .win_col_o(win_col_a)
    );

    ifm_fetch_ctrl #(.IMG_W(4), .IMG_H(3), .TAPS(TAPS), .ADDR_W(8), .IDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .mem_en_o(mem_en_b), .mem_addr_o(mem_addr_b), .ifm_read_o(ifm_read_b),
        .win_valid_o(win_valid_b), .win_ready_i(win_ready),
        .win_row_o(win_row_b), .win_col_o(win_col_b)
    );

    assign busy_m      = sel ? busy_b      : busy_a;
    assign done_m      = sel ? done_b      : done_a;
    assign mem_en_m    = sel ? mem_en_b    : mem_en_a;
    assign ifm_read_m  = sel ? ifm_read_b  : ifm_read_a;
    assign win_valid_m = sel ? win_valid_b : win_valid_a;
    assign mem_addr_m  = sel ? mem_addr_b  : mem_addr_a;
    assign win_row_m   = sel ? win_row_b   : win_row_a;
    assign win_col_m   = sel ? win_col_b   : win_col_a;

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit rdy(input int c);
        if (mode == 1) return !(c >= 6 && c <= 9);
        return 1'b1;
    endfunction

    // Expected frame schedule: each row fills TAPS pixels, its first window is
    // valid TAPS+1 cycles after the fill starts, every later window 2 cycles
    // after the previous handshake; the next row (or done) follows the last one.
    task automatic build(input int w, input int h);
        int t;
        int v;
        int hs;
        fq.delete();
        wq.delete();
        t = 1;
        hs = 0;
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < TAPS; k++) fq.push_back('{t + k, r * w + k, 0, 0});
            v = t + TAPS + 1;
            for (int j = 0; j <= w - TAPS; j++) begin
                hs = v;
                while (!rdy(hs)) hs++;
                wq.push_back('{v, r, j, hs});
                if (j < w - TAPS) begin
                    fq.push_back('{hs, r * w + TAPS + j, 0, 0});
                    v = hs + 2;
                end
            end
            t = hs + 1;
        end
        done_cyc = t;
    endtask

    // Per-cycle monitor: drive win_ready for this cycle, then score outputs.
    always @(negedge clk) begin
        int c;
        ev_t e;
        c = tick - base;
        win_ready = rdy(c);
        #1;
        if (active && !rst) begin
            chk("busy", busy_m, (c >= 1 && c <= done_cyc));
            chk("ifm_read_lag", ifm_read_m, prev_me);
            prev_me = mem_en_m;
            if (win_valid_m && !win_ready) chk("stall_mem_en", mem_en_m, 0);
            if (mem_en_m) begin
                if (fq.size() == 0) chk("fetch_extra", mem_en_m, 0);
                else begin
                    e = fq.pop_front();
                    chk("fetch_cycle", c, e.c);
                    chk("fetch_addr", mem_addr_m, e.a);
                end
            end
            if (win_valid_m) begin
                if (wq.size() == 0) chk("valid_extra", win_valid_m, 0);
                else begin
                    e = wq[0];
                    chk("win_row", win_row_m, e.a);
                    chk("win_col", win_col_m, e.b);
                    if (!seen) begin
                        chk("valid_cycle", c, e.c);
                        seen = 1'b1;
                    end
                    if (win_ready) begin
                        chk("hs_cycle", c, e.d);
                        void'(wq.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (done_m) begin
                chk("done_cycle", c, done_cyc);
                ndone++;
            end
        end
    end

    task automatic run_frame(input bit s, input int m, input bit stray);
        @(posedge clk); #2;
        sel = s;
        mode = m;
        if (s) build(4, 3);
        else build(6, 2);
        prev_me = 1'b0;
        ndone = 0;
        seen = 1'b0;
        base = tick;
        if (s) start_b = 1'b1;
        else start_a = 1'b1;
        active = 1'b1;
        @(posedge clk); #2;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k < 200 && (tick - base) < done_cyc + 3; k++) begin
            if (stray && (tick - base) == 8) start_a = 1'b1;
            else start_a = 1'b0;
            @(posedge clk); #2;
        end
        start_a = 1'b0;
        active = 1'b0;
        chk("fetch_left", fq.size(), 0);
        chk("win_left", wq.size(), 0);
        chk("done_count", ndone, 1);
        chk("idle_busy", busy_m, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_mem_en"}, mem_en_a, 0);
        chk({tag, "_ifm_read"}, ifm_read_a, 0);
        chk({tag, "_win_valid"}, win_valid_a, 0);
        chk({tag, "_mem_addr"}, mem_addr_a, 0);
        chk({tag, "_win_col"}, win_col_a, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;

        // Basic frame, backpressure, stray start while busy
        run_frame(1'b0, 0, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        run_frame(1'b0, 0, 1'b1);

        // Reset in the middle of the fill
        @(posedge clk); #2;
        mode = 0;
        sel = 1'b0;
        base = tick;
        start_a = 1'b1;
        @(posedge clk); #2;
        start_a = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("midfill_mem_en", mem_en_a, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_zero("post_reset");
            @(posedge clk); #2;
        end

        // Fresh frame after reset starts again at address 0
        run_frame(1'b0, 0, 1'b0);

        // IMG_W == TAPS, three rows
        run_frame(1'b1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
